// File: rtl/fp_op_issuer.sv
`timescale 1ns/1ps
// fp_op_issuer
//   Initiator for the AXI-Stream operand/result channels of an fp core
//   (fp_add/fp_sub/fp_mult/fp_div). It accepts a tagged operand pair from the
//   solver datapath and issues A and B to the core. Each core result is
//   returned combinationally together with the tag of the oldest
//   outstanding op.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   req_valid/ready/a/b/tag    tagged operand pair from the datapath
//   s_axis_a_*, s_axis_b_*     operand channels to the core
//   m_axis_result_*            result channel from the core
//   rsp_valid/ready/data/tag   tagged result to the consumer
//   busy                       op being issued or results outstanding
//   err_orphan                 sticky: a result arrived with nothing outstanding
module fp_op_issuer #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             s_axis_a_tvalid,
    input  logic             s_axis_a_tready,
    output logic [WIDTH-1:0] s_axis_a_tdata,
    output logic             s_axis_b_tvalid,
    input  logic             s_axis_b_tready,
    output logic [WIDTH-1:0] s_axis_b_tdata,
    input  logic             m_axis_result_tvalid,
    output logic             m_axis_result_tready,
    input  logic [WIDTH-1:0] m_axis_result_tdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             err_orphan
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               a_tvalid_q, a_tvalid_d;
    logic               b_tvalid_q, b_tvalid_d;
    logic [WIDTH-1:0]   a_tdata_q, a_tdata_d;
    logic [WIDTH-1:0]   b_tdata_q, b_tdata_d;
    logic [TAG_W-1:0]   tag_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_orphan_q, err_orphan_d;

    logic               accept;
    logic               pop;
    logic               empty;

    assign empty     = (count_q == '0);
    assign req_ready = (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept    = req_valid && req_ready;

    // Result path is purely combinational; with nothing outstanding the
    // result is swallowed so a stray core output cannot stall the channel.
    assign rsp_valid            = m_axis_result_tvalid && !empty;
    assign rsp_data             = m_axis_result_tdata;
    assign rsp_tag              = tag_mem_q[rd_ptr_q];
    assign m_axis_result_tready = empty ? 1'b1 : rsp_ready;
    assign pop                  = rsp_valid && rsp_ready;

    assign s_axis_a_tvalid = a_tvalid_q;
    assign s_axis_b_tvalid = b_tvalid_q;
    assign s_axis_a_tdata  = a_tdata_q;
    assign s_axis_b_tdata  = b_tdata_q;
    assign busy            = (state_q != IDLE) || !empty;
    assign err_orphan      = err_orphan_q;

    // Issue FSM: each operand channel retires on its own handshake; the
    // state returns to IDLE once neither channel is still valid.
    always_comb begin
        state_d    = state_q;
        a_tvalid_d = a_tvalid_q;
        b_tvalid_d = b_tvalid_q;
        a_tdata_d  = a_tdata_q;
        b_tdata_d  = b_tdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_tdata_d  = req_a;
                    b_tdata_d  = req_b;
                    a_tvalid_d = 1'b1;
                    b_tvalid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (a_tvalid_q && s_axis_a_tready) a_tvalid_d = 1'b0;
                if (b_tvalid_q && s_axis_b_tready) b_tvalid_d = 1'b0;
                if (!a_tvalid_d && !b_tvalid_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO bookkeeping; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (accept && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !accept) count_d = count_q - CNT_W'(1);
        if (m_axis_result_tvalid && empty) err_orphan_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_tvalid_q   <= 1'b0;
            b_tvalid_q   <= 1'b0;
            a_tdata_q    <= '0;
            b_tdata_q    <= '0;
            tag_mem_q    <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_tvalid_q   <= a_tvalid_d;
            b_tvalid_q   <= b_tvalid_d;
            a_tdata_q    <= a_tdata_d;
            b_tdata_q    <= b_tdata_d;
            if (accept) tag_mem_q[wr_ptr_q] <= req_tag;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule

// File: tb/tb_fp_op_issuer.sv
`timescale 1ns/1ps
// Directed bench for fp_op_issuer: reset, single op, independent channel
// handshakes, full FIFO, streamed ops with a latency-3 core, orphan results
// and reset during issue.
module tb_fp_op_issuer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic        s_axis_a_tvalid;
    logic        s_axis_a_tready;
    logic [31:0] s_axis_a_tdata;
    logic        s_axis_b_tvalid;
    logic        s_axis_b_tready;
    logic [31:0] s_axis_b_tdata;
    logic        m_axis_result_tvalid;
    logic        m_axis_result_tready;
    logic [31:0] m_axis_result_tdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic        err_orphan;

    int pass_cnt = 0;
    int total_cnt = 0;

    fp_op_issuer #(.WIDTH(32), .TAG_W(4), .DEPTH(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_a                (req_a),
        .req_b                (req_b),
        .req_tag              (req_tag),
        .s_axis_a_tvalid      (s_axis_a_tvalid),
        .s_axis_a_tready      (s_axis_a_tready),
        .s_axis_a_tdata       (s_axis_a_tdata),
        .s_axis_b_tvalid      (s_axis_b_tvalid),
        .s_axis_b_tready      (s_axis_b_tready),
        .s_axis_b_tdata       (s_axis_b_tdata),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tready (m_axis_result_tready),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_data             (rsp_data),
        .rsp_tag              (rsp_tag),
        .busy                 (busy),
        .err_orphan           (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper only: issues one op with both treadys assumed high.
    // Starts and ends 1 time unit after a rising edge, DUT back in IDLE.
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        s_axis_a_tready = 1'b0; s_axis_b_tready = 1'b0;
        m_axis_result_tvalid = 1'b0; m_axis_result_tdata = '0;
        rsp_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if ({req_ready, rsp_valid, busy, err_orphan} !== 4'b1000)
            $display("FAIL reset_flags: got rdy/rspv/busy/orph=%b expected 1000",
                     {req_ready, rsp_valid, busy, err_orphan});
        else pass_cnt++;
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid} !== 2'b00)
            $display("FAIL reset_tvalid: got %b expected 00", {s_axis_a_tvalid, s_axis_b_tvalid});
        else pass_cnt++;
        total_cnt++;
        if ({s_axis_a_tdata, s_axis_b_tdata} !== 64'h0)
            $display("FAIL reset_tdata: got %h/%h expected 0/0", s_axis_a_tdata, s_axis_b_tdata);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
        req_valid = 1'b1; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_tag = 4'd5;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL t1_req_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy} !== 4'b1101)
            $display("FAIL t1_issue: got atv/btv/rdy/busy=%b expected 1101",
                     {s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy});
        else pass_cnt++;
        total_cnt++;
        if (s_axis_a_tdata !== 32'h3F80_0000 || s_axis_b_tdata !== 32'h4000_0000)
            $display("FAIL t1_tdata: got %h/%h expected 3f800000/40000000", s_axis_a_tdata, s_axis_b_tdata);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy} !== 4'b0011)
            $display("FAIL t1_done: got atv/btv/rdy/busy=%b expected 0011",
                     {s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy});
        else pass_cnt++;
        // Core result for 1.0 + 2.0 = 3.0
        m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h4040_0000; rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h4040_0000 || rsp_tag !== 4'd5 || m_axis_result_tready !== 1'b1)
            $display("FAIL t1_rsp: got v=%b data=%h tag=%0d trdy=%b expected v=1 data=40400000 tag=5 trdy=1",
                     rsp_valid, rsp_data, rsp_tag, m_axis_result_tready);
        else pass_cnt++;
        @(posedge clk); #1;
        m_axis_result_tvalid = 1'b0; rsp_ready = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL t1_idle: got busy=%b rspv=%b expected 0/0", busy, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_independent;
        @(posedge clk); #1;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b0;
        req_valid = 1'b1; req_a = 32'hAAAA_0001; req_b = 32'hBBBB_0002; req_tag = 4'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // ISSUE cycle 0: A handshakes now, B stalls until cycle 3
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid} !== 2'b11)
            $display("FAIL t2_c0: got atv/btv=%b expected 11", {s_axis_a_tvalid, s_axis_b_tvalid});
        else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({s_axis_a_tvalid, s_axis_b_tvalid, req_ready} !== 3'b010 || s_axis_b_tdata !== 32'hBBBB_0002)
                $display("FAIL t2_c%0d: got atv/btv/rdy=%b bdata=%h expected 010 bbbb0002",
                         c, {s_axis_a_tvalid, s_axis_b_tvalid, req_ready}, s_axis_b_tdata);
            else pass_cnt++;
        end
        s_axis_b_tready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({s_axis_b_tvalid, req_ready} !== 2'b01)
            $display("FAIL t2_c4: got btv/rdy=%b expected 01", {s_axis_b_tvalid, req_ready});
        else pass_cnt++;
        m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h0000_0077; rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1)
            $display("FAIL t2_rsp: got v=%b tag=%0d expected v=1 tag=1", rsp_valid, rsp_tag);
        else pass_cnt++;
        @(posedge clk); #1;
        m_axis_result_tvalid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_full;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1; rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) issue_op(32'h10 + t, 32'h20 + t, 4'(t));
        total_cnt++;
        if (req_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL t3_full: got rdy=%b busy=%b expected 0/1", req_ready, busy);
        else pass_cnt++;
        m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h0000_0100; rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || req_ready !== 1'b0)
            $display("FAIL t3_pop: got v=%b tag=%0d rdy=%b expected v=1 tag=0 rdy=0", rsp_valid, rsp_tag, req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_tag !== 4'd1)
            $display("FAIL t3_after_pop: got rdy=%b tag=%0d expected rdy=1 tag=1", req_ready, rsp_tag);
        else pass_cnt++;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(k))
                $display("FAIL t3_drain: got v=%b tag=%0d expected v=1 tag=%0d", rsp_valid, rsp_tag, k);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        m_axis_result_tvalid = 1'b0; rsp_ready = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t3_empty: got busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    // Streams 8 ops through a latency-3 in-order core model while the
    // consumer alternates ready, so the FIFO fills, drains and wraps.
    task automatic test_back_to_back;
        int          sent;
        int          got;
        logic [31:0] q_data[$];
        int          q_rdy[$];
        logic [31:0] exp_data;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            req_valid = (sent < 8);
            req_a     = 32'h0000_0100 + sent;
            req_b     = 32'h0000_0200 + sent;
            req_tag   = 4'(sent);
            rsp_ready = cyc[0];
            if (q_rdy.size() > 0 && q_rdy[0] <= cyc) begin
                m_axis_result_tvalid = 1'b1;
                m_axis_result_tdata  = q_data[0];
            end else begin
                m_axis_result_tvalid = 1'b0;
            end
            #1;
            if (sent - got == 4) begin
                total_cnt++;
                if (req_ready !== 1'b0) $display("FAIL t4_full_ready: got %b expected 0 at cycle %0d", req_ready, cyc);
                else pass_cnt++;
            end
            if (s_axis_a_tvalid) begin
                q_data.push_back(s_axis_a_tdata ^ 32'hC000_0000);
                q_rdy.push_back(cyc + 3);
            end
            if (m_axis_result_tvalid && m_axis_result_tready) begin
                exp_data = (32'h0000_0100 + got) ^ 32'hC000_0000;
                total_cnt++;
                if (rsp_valid !== 1'b1 || rsp_tag !== 4'(got) || rsp_data !== exp_data)
                    $display("FAIL t4_rsp: got v=%b tag=%0d data=%h expected v=1 tag=%0d data=%h",
                             rsp_valid, rsp_tag, rsp_data, got, exp_data);
                else pass_cnt++;
                got++;
                void'(q_data.pop_front());
                void'(q_rdy.pop_front());
            end
            if (req_valid && req_ready) sent++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; m_axis_result_tvalid = 1'b0; rsp_ready = 1'b0;
        total_cnt++;
        if (got != 8 || busy !== 1'b0)
            $display("FAIL t4_complete: got %0d results busy=%b expected 8 results busy=0", got, busy);
        else pass_cnt++;
    endtask

    task automatic test_orphan;
        m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h1234_5678; rsp_ready = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || m_axis_result_tready !== 1'b1 || err_orphan !== 1'b0)
            $display("FAIL t5_drop: got v=%b trdy=%b orph=%b expected 0/1/0",
                     rsp_valid, m_axis_result_tready, err_orphan);
        else pass_cnt++;
        @(posedge clk); #1;
        m_axis_result_tvalid = 1'b0;
        total_cnt++;
        if (err_orphan !== 1'b1) $display("FAIL t5_set: got %b expected 1", err_orphan);
        else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if (err_orphan !== 1'b1) $display("FAIL t5_sticky: got %b expected 1", err_orphan);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_issue;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
        issue_op(32'h1, 32'h2, 4'd8);
        s_axis_a_tready = 1'b0; s_axis_b_tready = 1'b0;
        req_valid = 1'b1; req_a = 32'h3; req_b = 32'h4; req_tag = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid, busy} !== 3'b111)
            $display("FAIL t6_pre: got atv/btv/busy=%b expected 111", {s_axis_a_tvalid, s_axis_b_tvalid, busy});
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy, err_orphan} !== 5'b00100)
            $display("FAIL t6_reset: got atv/btv/rdy/busy/orph=%b expected 00100",
                     {s_axis_a_tvalid, s_axis_b_tvalid, req_ready, busy, err_orphan});
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
        issue_op(32'h5, 32'h6, 4'd10);
        m_axis_result_tvalid = 1'b1; m_axis_result_tdata = 32'h0000_00AB; rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd10)
            $display("FAIL t6_fresh: got v=%b tag=%0d expected v=1 tag=10", rsp_valid, rsp_tag);
        else pass_cnt++;
        @(posedge clk); #1;
        m_axis_result_tvalid = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_independent();
        test_full();
        test_back_to_back();
        test_orphan();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
